// File: rtl/ws_led_pkg.sv
// ws_led_pkg: definitions shared by the WS2801-style LED node.
//   node_state_t   - LOAD while collecting this node's word, RELAY while
//                    forwarding the rest of the stream downstream.
//   WS_*           - default parameter values for the node.
//   ws_total_bits  - colour word width for a channel/bit configuration.
package ws_led_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    RELAY = 1'b1
  } node_state_t;

  localparam int WS_CHANNELS     = 3;
  localparam int WS_CHAN_BITS    = 8;
  localparam int WS_LATCH_CYCLES = 25000;
  localparam int WS_SYNC_STAGES  = 2;

  function automatic int ws_total_bits(input int ch, input int bits);
    return ch * bits;
  endfunction

endpackage

// File: rtl/ws_input_sync.sv
// ws_input_sync: brings the asynchronous serial clock/data into the clk
// domain and detects rising edges of the synchronised serial clock.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   cki, sdi  - raw serial clock / data pins (asynchronous)
//   cki_s     - cki after SYNC_STAGES flops
//   sdi_s     - sdi after SYNC_STAGES flops (same latency as cki_s)
//   cki_rise  - high for one cycle when cki_s goes 0 -> 1
module ws_input_sync
  import ws_led_pkg::*;
#(
  parameter int SYNC_STAGES = WS_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic cki,
  input  logic sdi,
  output logic cki_s,
  output logic sdi_s,
  output logic cki_rise
);

  logic [SYNC_STAGES-1:0] cki_pipe;
  logic [SYNC_STAGES-1:0] sdi_pipe;
  logic                   cki_prev;

  // Both lines go through identical pipelines so data keeps its phase
  // relative to the clock it was launched with.
  always_ff @(posedge clk) begin
    if (rst) begin
      cki_pipe <= '0;
      sdi_pipe <= '0;
      cki_prev <= 1'b0;
    end else begin
      cki_pipe <= {cki_pipe[SYNC_STAGES-2:0], cki};
      sdi_pipe <= {sdi_pipe[SYNC_STAGES-2:0], sdi};
      cki_prev <= cki_pipe[SYNC_STAGES-1];
    end
  end

  assign cki_s    = cki_pipe[SYNC_STAGES-1];
  assign sdi_s    = sdi_pipe[SYNC_STAGES-1];
  assign cki_rise = cki_s & ~cki_prev;

endmodule

// File: rtl/ws_led_node.sv
// ws_led_node: synthesizable WS2801-style LED node.
// Shifts in one colour word (CHANNELS*CHAN_BITS bits, MSB first) from the
// oversampled serial stream, then relays the remainder of the stream on
// cko/sdo. After LATCH_CYCLES clk cycles with no serial clock edge, a
// complete word is latched onto color; a partial word is dropped and flagged.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   sdi, cki      - serial data / clock in (asynchronous)
//   sdo, cko      - relayed serial data / clock (to the next node)
//   color         - latched colour word, channel 0 in the top bits
//   latch_pulse   - one-cycle strobe when color updates
//   frame_err     - one-cycle strobe when a partial frame is discarded
//   relay_active  - node is forwarding (RELAY state)
module ws_led_node
  import ws_led_pkg::*;
#(
  parameter int CHANNELS     = WS_CHANNELS,
  parameter int CHAN_BITS    = WS_CHAN_BITS,
  parameter int LATCH_CYCLES = WS_LATCH_CYCLES,
  parameter int SYNC_STAGES  = WS_SYNC_STAGES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sdi,
  input  logic                          cki,
  output logic                          sdo,
  output logic                          cko,
  output logic [CHANNELS*CHAN_BITS-1:0] color,
  output logic                          latch_pulse,
  output logic                          frame_err,
  output logic                          relay_active
);

  localparam int TOTAL  = ws_total_bits(CHANNELS, CHAN_BITS);
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int IDLE_W = $clog2(LATCH_CYCLES + 1);

  localparam logic [CNT_W-1:0]  TOTAL_CNT = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TOTAL - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(LATCH_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_GAP  = IDLE_W'(LATCH_CYCLES - 1);

  logic              cki_s;
  logic              sdi_s;
  logic              cki_rise;

  node_state_t       state;
  logic [TOTAL-1:0]  shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              armed;

  logic              gap_event;
  logic              arm_now;

  ws_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .cki     (cki),
    .sdi     (sdi),
    .cki_s   (cki_s),
    .sdi_s   (sdi_s),
    .cki_rise(cki_rise)
  );

  // The gap fires on the single cycle the idle counter would step onto
  // LATCH_CYCLES. A coincident edge clears the counter instead, so the edge
  // wins. Once saturated the counter sits at LATCH_CYCLES, not LATCH_CYCLES-1,
  // so the event cannot repeat until a new edge restarts the count.
  assign gap_event = !cki_rise && (idle_cnt == IDLE_GAP);

  // Forwarding becomes live at the first RELAY cycle with cki_s low. This
  // keeps the high tail of this node's final clock pulse from being relayed
  // as a spurious pulse.
  assign arm_now = (state == RELAY) && (armed || !cki_s);

  // Node control: shift/count in LOAD, forward in RELAY, and on an idle gap
  // latch or discard the frame and return to LOAD. All outputs are
  // registered so cko and sdo see one extra flop of identical latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      idle_cnt     <= '0;
      armed        <= 1'b0;
      color        <= '0;
      latch_pulse  <= 1'b0;
      frame_err    <= 1'b0;
      relay_active <= 1'b0;
      cko          <= 1'b0;
      sdo          <= 1'b0;
    end else begin
      latch_pulse <= 1'b0;
      frame_err   <= 1'b0;

      if (cki_rise) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (gap_event) begin
        if (bit_cnt == TOTAL_CNT) begin
          color       <= shift_reg;
          latch_pulse <= 1'b1;
        end else if (bit_cnt != '0) begin
          frame_err <= 1'b1;
        end
        bit_cnt      <= '0;
        state        <= LOAD;
        armed        <= 1'b0;
        relay_active <= 1'b0;
        cko          <= 1'b0;
        sdo          <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            armed <= 1'b0;
            cko   <= 1'b0;
            sdo   <= 1'b0;
            if (cki_rise) begin
              shift_reg <= {shift_reg[TOTAL-2:0], sdi_s};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_CNT) begin
                state        <= RELAY;
                relay_active <= 1'b1;
              end
            end
          end
          RELAY: begin
            relay_active <= 1'b1;
            armed        <= arm_now;
            cko          <= arm_now & cki_s;
            sdo          <= arm_now & sdi_s;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ws_led_node.sv
// tb_ws_led_node: directed self-checking bench for ws_led_node.
// Three configurations are instantiated: a single 24-bit node, a five-node
// 24-bit chain and a single 48-bit node (4 x 12), all with a 100-cycle latch
// gap. One serial driver is steered to the configuration under test.
module tb_ws_led_node;
  import ws_led_pkg::*;

  localparam int LC   = 100;
  localparam int HALF = 8;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cki_drv = 1'b0;
  logic sdi_drv = 1'b0;
  int   sel = 0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Single 24-bit node
  logic        cki_a, sdi_a, cko_a, sdo_a, lp_a, fe_a, relay_a;
  logic [23:0] color_a;
  assign cki_a = (sel == 0) ? cki_drv : 1'b0;
  assign sdi_a = (sel == 0) ? sdi_drv : 1'b0;

  ws_led_node #(.LATCH_CYCLES(LC)) u_a (
    .clk(clk), .rst(rst), .sdi(sdi_a), .cki(cki_a), .sdo(sdo_a), .cko(cko_a),
    .color(color_a), .latch_pulse(lp_a), .frame_err(fe_a), .relay_active(relay_a)
  );

  // Five-node chain
  logic        ch_cki   [0:5];
  logic        ch_sdi   [0:5];
  logic [23:0] ch_color [0:4];
  logic        ch_latch [0:4];
  logic        ch_err   [0:4];
  logic        ch_relay [0:4];
  assign ch_cki[0] = (sel == 1) ? cki_drv : 1'b0;
  assign ch_sdi[0] = (sel == 1) ? sdi_drv : 1'b0;

  for (genvar g = 0; g < 5; g++) begin : g_chain
    ws_led_node #(.LATCH_CYCLES(LC)) u_node (
      .clk(clk), .rst(rst), .sdi(ch_sdi[g]), .cki(ch_cki[g]),
      .sdo(ch_sdi[g+1]), .cko(ch_cki[g+1]), .color(ch_color[g]),
      .latch_pulse(ch_latch[g]), .frame_err(ch_err[g]), .relay_active(ch_relay[g])
    );
  end

  // Single 48-bit node
  logic        cki_w, sdi_w, cko_w, sdo_w, lp_w, fe_w, relay_w;
  logic [47:0] color_w;
  assign cki_w = (sel == 2) ? cki_drv : 1'b0;
  assign sdi_w = (sel == 2) ? sdi_drv : 1'b0;

  ws_led_node #(.CHANNELS(4), .CHAN_BITS(12), .LATCH_CYCLES(LC)) u_w (
    .clk(clk), .rst(rst), .sdi(sdi_w), .cki(cki_w), .sdo(sdo_w), .cko(cko_w),
    .color(color_w), .latch_pulse(lp_w), .frame_err(fe_w), .relay_active(relay_w)
  );

  // Event monitors, sampled on the falling edge
  int          cyc = 0;
  int          latch_cnt_a = 0, err_cnt_a = 0, latch_cnt_w = 0, err_cnt_w = 0;
  int          both_cnt = 0;
  int          ch_latch_cnt [0:4] = '{default: 0};
  int          ch_err_cnt   [0:4] = '{default: 0};
  int          ch_latch_cyc [0:4] = '{default: 0};
  int          cko_rises = 0, sdo_rises = 0, cko_lag_bad = 0, sdo_lag_bad = 0;
  logic [23:0] sdo_seq = '0;
  logic        cko_prev = 1'b0, sdo_prev = 1'b0;
  logic [3:0]  cki_hist = '0, sdi_hist = '0;

  always @(posedge clk) cyc++;

  // cki_hist[0] is the pin value one falling edge ago; the relayed outputs
  // are expected to trail the pins by SYNC+1 cycles, i.e. hist[2].
  always @(negedge clk) begin
    if (lp_a) latch_cnt_a++;
    if (fe_a) err_cnt_a++;
    if (lp_w) latch_cnt_w++;
    if (fe_w) err_cnt_w++;
    if ((lp_a && fe_a) || (lp_w && fe_w)) both_cnt++;
    for (int k = 0; k < 5; k++) begin
      if (ch_latch[k]) begin
        ch_latch_cnt[k]++;
        ch_latch_cyc[k] = cyc;
      end
      if (ch_err[k]) ch_err_cnt[k]++;
      if (ch_latch[k] && ch_err[k]) both_cnt++;
    end
    if (cko_a && !cko_prev) begin
      cko_rises++;
      sdo_seq = {sdo_seq[22:0], sdo_a};
      if (!(cki_hist[SYNC] && !cki_hist[SYNC+1])) cko_lag_bad++;
    end
    if (sdo_a && !sdo_prev) begin
      sdo_rises++;
      if (!(sdi_hist[SYNC] && !sdi_hist[SYNC+1])) sdo_lag_bad++;
    end
    cko_prev = cko_a;
    sdo_prev = sdo_a;
    cki_hist = {cki_hist[2:0], cki_a};
    sdi_hist = {sdi_hist[2:0], sdi_a};
  end

  // Stimulus helpers; every call starts and ends 2 ns after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    cki_drv = 1'b0;
    sdi_drv = b;
    step(HALF);
    cki_drv = 1'b1;
    step(HALF);
  endtask

  task automatic send_bits(input logic [47:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    cki_drv = 1'b0;
    sdi_drv = 1'b0;
    step(n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(3);
    @(negedge clk);
    total++; if (color_a !== 24'h0) $display("[TB] FAIL reset_color_a: got %h want %h", color_a, 24'h0); else passed++;
    total++; if (color_w !== 48'h0) $display("[TB] FAIL reset_color_w: got %h want %h", color_w, 48'h0); else passed++;
    total++; if (ch_color[0] !== 24'h0) $display("[TB] FAIL reset_color_ch0: got %h want %h", ch_color[0], 24'h0); else passed++;
    total++; if ({relay_a, cko_a, sdo_a, lp_a, fe_a} !== 5'b0) $display("[TB] FAIL reset_outputs: got %b want %b", {relay_a, cko_a, sdo_a, lp_a, fe_a}, 5'b0); else passed++;
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_full_latch;
    int base;
    sel = 0;
    base = latch_cnt_a;
    send_bits(48'hFFFFFF, 24);
    @(negedge clk);
    total++; if (relay_a !== 1'b1) $display("[TB] FAIL full_relay_on: got %b want %b", relay_a, 1'b1); else passed++;
    total++; if (cko_a !== 1'b0) $display("[TB] FAIL full_cko_tail: got %b want %b", cko_a, 1'b0); else passed++;
    idle(120);
    @(negedge clk);
    total++; if (latch_cnt_a - base !== 1) $display("[TB] FAIL full_latch_count: got %0d want %0d", latch_cnt_a - base, 1); else passed++;
    total++; if (color_a !== 24'hFFFFFF) $display("[TB] FAIL full_color: got %h want %h", color_a, 24'hFFFFFF); else passed++;
    total++; if (relay_a !== 1'b0) $display("[TB] FAIL full_relay_off: got %b want %b", relay_a, 1'b0); else passed++;
    step(1);
  endtask

  task automatic test_relay_forward;
    int base_l, base_c, base_s, base_cb, base_sb;
    sel = 0;
    base_l  = latch_cnt_a;
    base_c  = cko_rises;
    base_s  = sdo_rises;
    base_cb = cko_lag_bad;
    base_sb = sdo_lag_bad;
    send_bits(48'hAAAAAA, 24);
    send_bits(48'h555555, 24);
    idle(120);
    @(negedge clk);
    total++; if (latch_cnt_a - base_l !== 1) $display("[TB] FAIL relay_latch_count: got %0d want %0d", latch_cnt_a - base_l, 1); else passed++;
    total++; if (color_a !== 24'hAAAAAA) $display("[TB] FAIL relay_color: got %h want %h", color_a, 24'hAAAAAA); else passed++;
    total++; if (cko_rises - base_c !== 24) $display("[TB] FAIL relay_cko_pulses: got %0d want %0d", cko_rises - base_c, 24); else passed++;
    total++; if (sdo_seq !== 24'h555555) $display("[TB] FAIL relay_sdo_bits: got %h want %h", sdo_seq, 24'h555555); else passed++;
    total++; if (sdo_rises - base_s !== 12) $display("[TB] FAIL relay_sdo_rises: got %0d want %0d", sdo_rises - base_s, 12); else passed++;
    total++; if (cko_lag_bad - base_cb !== 0) $display("[TB] FAIL relay_cko_lag: got %0d bad edges want %0d", cko_lag_bad - base_cb, 0); else passed++;
    total++; if (sdo_lag_bad - base_sb !== 0) $display("[TB] FAIL relay_sdo_lag: got %0d bad edges want %0d", sdo_lag_bad - base_sb, 0); else passed++;
    total++; if ({cko_a, sdo_a} !== 2'b00) $display("[TB] FAIL relay_idle_outputs: got %b want %b", {cko_a, sdo_a}, 2'b00); else passed++;
    step(1);
  endtask

  task automatic test_chain;
    int base_l [0:4];
    int base_e [0:4];
    int first_cyc, last_cyc;
    sel = 1;
    for (int k = 0; k < 5; k++) begin
      base_l[k] = ch_latch_cnt[k];
      base_e[k] = ch_err_cnt[k];
    end
    for (int k = 0; k < 5; k++) send_bits(48'(24'(24'h111111 * (k + 1))), 24);
    idle(150);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      total++; if (ch_color[k] !== 24'(24'h111111 * (k + 1))) $display("[TB] FAIL chain_color_%0d: got %h want %h", k, ch_color[k], 24'(24'h111111 * (k + 1))); else passed++;
      total++; if (ch_latch_cnt[k] - base_l[k] !== 1) $display("[TB] FAIL chain_latch_count_%0d: got %0d want %0d", k, ch_latch_cnt[k] - base_l[k], 1); else passed++;
      total++; if (ch_err_cnt[k] - base_e[k] !== 0) $display("[TB] FAIL chain_err_count_%0d: got %0d want %0d", k, ch_err_cnt[k] - base_e[k], 0); else passed++;
    end
    first_cyc = ch_latch_cyc[0];
    last_cyc  = ch_latch_cyc[0];
    for (int k = 1; k < 5; k++) begin
      if (ch_latch_cyc[k] < first_cyc) first_cyc = ch_latch_cyc[k];
      if (ch_latch_cyc[k] > last_cyc) last_cyc = ch_latch_cyc[k];
    end
    total++; if (last_cyc - first_cyc > 5 * (SYNC + 1)) $display("[TB] FAIL chain_latch_spread: got %0d cycles want at most %0d", last_cyc - first_cyc, 5 * (SYNC + 1)); else passed++;
    total++; if ({ch_relay[4], ch_cki[5], ch_sdi[5]} !== 3'b000) $display("[TB] FAIL chain_tail_idle: got %b want %b", {ch_relay[4], ch_cki[5], ch_sdi[5]}, 3'b000); else passed++;
    step(1);
  endtask

  task automatic test_partial_frame;
    int base_l, base_e;
    sel = 0;
    base_l = latch_cnt_a;
    base_e = err_cnt_a;
    send_bits(48'h3FF, 10);
    idle(120);
    @(negedge clk);
    total++; if (err_cnt_a - base_e !== 1) $display("[TB] FAIL partial_err_count: got %0d want %0d", err_cnt_a - base_e, 1); else passed++;
    total++; if (latch_cnt_a - base_l !== 0) $display("[TB] FAIL partial_no_latch: got %0d want %0d", latch_cnt_a - base_l, 0); else passed++;
    total++; if (color_a !== 24'hAAAAAA) $display("[TB] FAIL partial_color_kept: got %h want %h", color_a, 24'hAAAAAA); else passed++;
    step(1);
    send_bits(48'h0F0F0F, 24);
    idle(120);
    @(negedge clk);
    total++; if (latch_cnt_a - base_l !== 1) $display("[TB] FAIL partial_next_latch: got %0d want %0d", latch_cnt_a - base_l, 1); else passed++;
    total++; if (color_a !== 24'h0F0F0F) $display("[TB] FAIL partial_next_color: got %h want %h", color_a, 24'h0F0F0F); else passed++;
    total++; if (err_cnt_a - base_e !== 1) $display("[TB] FAIL partial_next_no_err: got %0d want %0d", err_cnt_a - base_e, 1); else passed++;
    step(1);
  endtask

  task automatic test_reset_mid_frame;
    int base_l, base_e;
    sel = 0;
    base_l = latch_cnt_a;
    base_e = err_cnt_a;
    send_bits(48'h123, 12);
    idle(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    total++; if (color_a !== 24'h0) $display("[TB] FAIL midrst_color: got %h want %h", color_a, 24'h0); else passed++;
    total++; if ({relay_a, cko_a, sdo_a, lp_a, fe_a} !== 5'b0) $display("[TB] FAIL midrst_outputs: got %b want %b", {relay_a, cko_a, sdo_a, lp_a, fe_a}, 5'b0); else passed++;
    step(1);
    idle(120);
    @(negedge clk);
    total++; if (latch_cnt_a - base_l !== 0) $display("[TB] FAIL midrst_no_latch: got %0d want %0d", latch_cnt_a - base_l, 0); else passed++;
    total++; if (err_cnt_a - base_e !== 0) $display("[TB] FAIL midrst_no_err: got %0d want %0d", err_cnt_a - base_e, 0); else passed++;
    step(1);
    send_bits(48'h123456, 24);
    idle(120);
    @(negedge clk);
    total++; if (latch_cnt_a - base_l !== 1) $display("[TB] FAIL midrst_next_latch: got %0d want %0d", latch_cnt_a - base_l, 1); else passed++;
    total++; if (color_a !== 24'h123456) $display("[TB] FAIL midrst_next_color: got %h want %h", color_a, 24'h123456); else passed++;
    step(1);
  endtask

  task automatic test_wide_and_edge_wins;
    int base_l, base_e;
    logic [47:0] w2;
    sel = 2;
    w2 = 48'h0123456789AB;
    base_l = latch_cnt_w;
    base_e = err_cnt_w;
    send_bits(48'hFEDCBA987654, 48);
    idle(120);
    @(negedge clk);
    total++; if (latch_cnt_w - base_l !== 1) $display("[TB] FAIL wide_latch_count: got %0d want %0d", latch_cnt_w - base_l, 1); else passed++;
    total++; if (color_w !== 48'hFEDCBA987654) $display("[TB] FAIL wide_color: got %h want %h", color_w, 48'hFEDCBA987654); else passed++;
    total++; if ({relay_w, cko_w, sdo_w} !== 3'b000) $display("[TB] FAIL wide_idle_outputs: got %b want %b", {relay_w, cko_w, sdo_w}, 3'b000); else passed++;
    step(1);
    // Second word: the final rising pin edge lands after posedge Q, so it is
    // detected SYNC edges later. An extra pin edge after posedge Q+LC is then
    // detected exactly when the idle count stands at LC-1.
    base_l = latch_cnt_w;
    for (int i = 47; i >= 1; i--) send_bit(w2[i]);
    cki_drv = 1'b0;
    sdi_drv = w2[0];
    step(HALF);
    cki_drv = 1'b1;
    for (int i = 1; i <= LC; i++) begin
      step(1);
      if (i == HALF) cki_drv = 1'b0;
      if (i == LC) cki_drv = 1'b1;
    end
    step(HALF);
    @(negedge clk);
    total++; if (latch_cnt_w - base_l !== 0) $display("[TB] FAIL edge_wins_no_latch: got %0d want %0d", latch_cnt_w - base_l, 0); else passed++;
    step(1);
    idle(120);
    @(negedge clk);
    total++; if (latch_cnt_w - base_l !== 1) $display("[TB] FAIL edge_wins_later_latch: got %0d want %0d", latch_cnt_w - base_l, 1); else passed++;
    total++; if (color_w !== w2) $display("[TB] FAIL edge_wins_color: got %h want %h", color_w, w2); else passed++;
    total++; if (err_cnt_w - base_e !== 0) $display("[TB] FAIL wide_no_err: got %0d want %0d", err_cnt_w - base_e, 0); else passed++;
    step(1);
  endtask

  task automatic test_strobe_exclusive;
    total++; if (both_cnt !== 0) $display("[TB] FAIL strobe_overlap: got %0d want %0d", both_cnt, 0); else passed++;
  endtask

  initial begin
    $display("[TB] ws_led_node directed bench starting");
    test_reset;
    test_full_latch;
    test_relay_forward;
    test_chain;
    test_partial_frame;
    test_reset_mid_frame;
    test_wide_and_edge_wins;
    test_strobe_exclusive;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ws_led_node.md
Name: ws_led_node

Overview:
- Synthesizable, parametrised WS2801-style LED node for FPGA use, replacing the behavioural-only LED model.
- Oversamples the incoming serial clock/data (cki/sdi) on the system clock and shifts in one colour word of CHANNELS×CHAN_BITS bits.
- Once the word is full, relays the remaining stream downstream on cko/sdo, and latches the word after an idle gap.
- Nodes chain sdo→sdi and cko→cki to form a strip. Complete frames are latched; partial frames are discarded and flagged.

Parameters:
- CHANNELS, 3, colour channels per node. Channel 0 is the MSB field (red).
- CHAN_BITS, 8, bits per channel. The word is MSB-first.
- LATCH_CYCLES, 25000, consecutive clk cycles without a cki rising edge that trigger a latch (500 us at 50 MHz).
- SYNC_STAGES, 2, synchroniser flops on cki/sdi. Minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sdi  input  1  serial data in, asynchronous to clk.
- cki  input  1  serial clock in, asynchronous to clk. High and low phases are each ≥ SYNC_STAGES+2 clk periods.
- sdo  output  1  relayed serial data.
- cko  output  1  relayed serial clock.
- color  output  CHANNELS*CHAN_BITS  latched colour word, channel 0 in the top bits.
- latch_pulse  output  1  one-cycle strobe when color updates.
- frame_err  output  1  one-cycle strobe when a partial frame is discarded.
- relay_active  output  1  node is in RELAY state.

Behaviour:
- Reset (rst=1 at a clk edge) clears: color, sdo, cko, latch_pulse, frame_err, relay_active, the shift register, bit counter, idle counter and synchroniser flops. State becomes LOAD.
- Reset mid-frame discards all partial data. No latch occurs.
- Define TOTAL = CHANNELS*CHAN_BITS.
- cki_s/sdi_s are the synchronised signals. A rising edge is cki_s=1 with previous cki_s=0. sdi_s is sampled in the same cycle the edge is detected.
- LOAD state, on each rising edge:
  - shift_reg <= {shift_reg[TOTAL-2:0], sdi_s}; bit_cnt++.
  - When the edge makes bit_cnt == TOTAL, go to RELAY on the next cycle. relay_active goes high one cycle after that edge is detected.
- RELAY state:
  - Further edges do not shift or count.
  - Forwarding is armed at the first cycle in RELAY where cki_s==0. This prevents forwarding the tail of the TOTAL-th clock pulse.
  - While armed: cko and sdo are registered copies of cki_s and sdi_s. Both carry equal latency, SYNC_STAGES+1 cycles from the pins, so data-to-clock phase is preserved.
  - While not armed, or in LOAD: cko=0, sdo=0.
- Idle counter:
  - Resets to 0 on any rising edge. Otherwise it increments, saturating at LATCH_CYCLES.
  - The cycle it reaches LATCH_CYCLES the gap event fires once. It does not fire again until a new edge occurs.
- Gap event:
  - If bit_cnt==TOTAL: color <= shift_reg, latch_pulse=1.
  - Else if bit_cnt>0: frame_err=1, color unchanged.
  - Else: no strobe.
  - In every case the following cycle has bit_cnt=0, state LOAD, forwarding disarmed, relay_active=0, cko=sdo=0.
- A rising edge detected in the same cycle the idle counter would reach LATCH_CYCLES wins: the edge is processed, the counter clears, and no gap event fires.
- The bit counter never exceeds TOTAL. Its width is $clog2(TOTAL+1).
- The idle counter width is $clog2(LATCH_CYCLES+1).
- latch_pulse and frame_err are never high together.

Decomposition:
- Shared package ws_led_pkg holds:
  - state enum node_state_t {LOAD, RELAY};
  - default constants WS_CHANNELS=3, WS_CHAN_BITS=8, WS_LATCH_CYCLES=25000;
  - the function ws_total_bits(ch, bits).
- One sub-module ws_input_sync holds the SYNC_STAGES synchroniser on cki/sdi plus cki rising-edge detect. It outputs cki_s, sdi_s and cki_rise.

Test Plan:
- Default params, LATCH_CYCLES=100 override, cki half-period 8 clk. Shift 24'hFFFFFF, then idle 120 cycles → latch_pulse once, color=24'hFFFFFF, relay_active back to 0.
- Shift 24'hAAAAAA then 24'h555555, then gap → color=24'hAAAAAA. cko replays exactly 24 pulses and the sdo bit sequence equals 24'h555555 MSB-first, with cko/sdo lag = SYNC_STAGES+1 cycles.
- 5-node chain fed five words 24'h111111…24'h555555, then gap → node k color = word k. All latch_pulse strobes fire in the same window (within 5×(SYNC_STAGES+1) cycles).
- Shift only 10 bits, then gap → frame_err once, color unchanged from previous frame, next full 24'h0F0F0F latches correctly.
- Assert rst for 1 cycle after bit 12 → all outputs 0, no latch_pulse on following gap, next frame 24'h123456 latches cleanly.
- CHANNELS=4, CHAN_BITS=12 (48-bit word 48'hFEDCBA987654) → correct latch. A rising edge placed exactly at idle count LATCH_CYCLES-1 suppresses the latch.
